// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Writeback request bus and regfile write-port signals of the
//            register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          Req0Valid;
    logic [AW-1:0] Req0Addr;
    logic [DW-1:0] Req0Data;
    logic          Req0Ready;
    logic          Req1Valid;
    logic [AW-1:0] Req1Addr;
    logic [DW-1:0] Req1Data;
    logic          Req1Ready;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic          InitDone;

    // The requester/regfile side drives the requests and observes the results.
    modport master (
        output Req0Valid, Req0Addr, Req0Data,
        output Req1Valid, Req1Addr, Req1Data,
        input  Req0Ready, Req1Ready,
        input  WriteRegister, WriteData, RegWrite, InitDone
    );

    modport slave (
        input  Req0Valid, Req0Addr, Req0Data,
        input  Req1Valid, Req1Addr, Req1Data,
        output Req0Ready, Req1Ready,
        output WriteRegister, WriteData, RegWrite, InitDone
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Clears registers 1..NREG-1 after reset, then round-robin
//            arbitrates two writeback requesters onto the regfile write port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [AW-1:0] c_last_reg = AW'(NREG - 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_last1;
    logic          r_regwrite;
    logic [AW-1:0] r_wreg;
    logic [DW-1:0] r_wdata;
    logic          r_initdone;

    logic          w_grant0;
    logic          w_grant1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    // Contention goes to whichever requester did not win the previous grant.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == S_RUN) begin
            if (bus.Req0Valid && bus.Req1Valid) begin
                w_grant0 = r_last1;
                w_grant1 = ~r_last1;
            end else begin
                w_grant0 = bus.Req0Valid;
                w_grant1 = bus.Req1Valid;
            end
        end
    end

    assign w_addr = w_grant1 ? bus.Req1Addr : bus.Req0Addr;
    assign w_data = w_grant1 ? bus.Req1Data : bus.Req0Data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_INIT;
            r_cnt      <= AW'(1);
            r_last1    <= 1'b1;
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_initdone <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_regwrite <= 1'b1;
                    r_wreg     <= r_cnt;
                    r_wdata    <= '0;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == c_last_reg) begin
                        r_initdone <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                default: begin
                    if (w_grant0 || w_grant1) begin
                        r_last1 <= w_grant1;
                        // Register 0 is accepted but never written; outputs hold.
                        if (w_addr != '0) begin
                            r_regwrite <= 1'b1;
                            r_wreg     <= w_addr;
                            r_wdata    <= w_data;
                        end else begin
                            r_regwrite <= 1'b0;
                        end
                    end else begin
                        r_regwrite <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.Req0Ready     = w_grant0;
    assign bus.Req1Ready     = w_grant1;
    assign bus.WriteRegister = r_wreg;
    assign bus.WriteData     = r_wdata;
    assign bus.RegWrite      = r_regwrite;
    assign bus.InitDone      = r_initdone;

endmodule
`default_nettype wire
